// File: rtl/proc_pkg.sv
// Shared ISA definitions for pipeline2: opcode encodings, field widths, operand decode helpers.
// Latency: none. All helpers are pure combinational functions.
// Backpressure: not applicable. This file holds no state and no handshakes.
package proc_pkg;

    localparam int OPC_W    = 6;
    localparam int REG_W    = 5;
    localparam int INSTR_W  = 32;
    localparam int NUM_REGS = 2**REG_W;

    // CALL writes the return address here and RET reads it back.
    localparam logic [REG_W-1:0] LINK_REG = REG_W'(NUM_REGS - 1);

    localparam logic [OPC_W-1:0] OP_LW     = 6'd0;
    localparam logic [OPC_W-1:0] OP_LW_IMM = 6'd1;
    localparam logic [OPC_W-1:0] OP_SW     = 6'd2;
    localparam logic [OPC_W-1:0] OP_ADD    = 6'd3;
    localparam logic [OPC_W-1:0] OP_SUB    = 6'd4;
    localparam logic [OPC_W-1:0] OP_MUL    = 6'd5;
    localparam logic [OPC_W-1:0] OP_DIV    = 6'd6;
    localparam logic [OPC_W-1:0] OP_AND    = 6'd7;
    localparam logic [OPC_W-1:0] OP_OR     = 6'd8;
    localparam logic [OPC_W-1:0] OP_NOT    = 6'd9;
    localparam logic [OPC_W-1:0] OP_CMP    = 6'd10;
    localparam logic [OPC_W-1:0] OP_JR     = 6'd11;
    localparam logic [OPC_W-1:0] OP_JPC    = 6'd12;
    localparam logic [OPC_W-1:0] OP_BRFL   = 6'd13;
    localparam logic [OPC_W-1:0] OP_CALL   = 6'd14;
    localparam logic [OPC_W-1:0] OP_RET    = 6'd15;
    localparam logic [OPC_W-1:0] OP_NOP    = 6'd16;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } hz_state_e;

    // The first source port also covers RET. Its source is the link register.
    // src1_addr selects that address.
    function automatic logic reads_r1(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
            OP_SW, OP_CMP, OP_JR, OP_RET: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic reads_r2(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
            OP_NOT, OP_LW, OP_SW, OP_CMP: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic writes_dest(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR,
            OP_NOT, OP_LW, OP_LW_IMM, OP_CALL: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [REG_W-1:0] src1_addr(input logic [OPC_W-1:0] op,
                                                   input logic [REG_W-1:0] r1);
        return (op == OP_RET) ? LINK_REG : r1;
    endfunction

    function automatic logic [REG_W-1:0] dest_addr(input logic [OPC_W-1:0] op,
                                                   input logic [REG_W-1:0] r1);
        return (op == OP_CALL) ? LINK_REG : r1;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Per-register pending-write bits. An issued writer sets its bit and a writeback clears it.
// Latency: lookups are combinational on registered bits. Updates are visible one cycle after the edge.
// Backpressure: none. Set and clear are accepted every cycle, and set wins on the same address.
// Ports: clk_in/RST (sync, active-high), set_en_i/set_addr_i, clr_en_i/clr_addr_i,
//        rd_a_addr_i->rd_a_pend_o, rd_b_addr_i->rd_b_pend_o, pending_o (full bit vector).
module scoreboard
    import proc_pkg::*;
#(
    parameter int AW = REG_W
) (
    input  logic              clk_in,
    input  logic              RST,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_addr_i,
    input  logic [AW-1:0]     rd_a_addr_i,
    output logic              rd_a_pend_o,
    input  logic [AW-1:0]     rd_b_addr_i,
    output logic              rd_b_pend_o,
    output logic [2**AW-1:0]  pending_o
);

    logic [2**AW-1:0] pending_q, pending_d;
    logic [2**AW-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en_i) set_mask[set_addr_i] = 1'b1;
        if (clr_en_i) clr_mask[clr_addr_i] = 1'b1;
        // The clear is applied first, so a new producer issued on the
        // writeback edge of an older one keeps the register marked busy.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk_in) begin
        if (RST) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    assign rd_a_pend_o = pending_q[rd_a_addr_i];
    assign rd_b_pend_o = pending_q[rd_b_addr_i];
    assign pending_o   = pending_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue control. Stalls ID on RAW, flag and MUL/DIV-occupancy hazards, and flushes IF/ID on EX redirect.
// Latency: issue/stall/flush are combinational in the same cycle. The scoreboard and busy state update at the edge.
// Backpressure: stall holds PC and IF/ID. While BUSY, stall holds for CYCLES-1 cycles after the multi-cycle op issues.
// Ports: clk_in/RST (sync, active-high), id_valid/id_instr, wb_en/wb_addr, flag_wb, ex_redirect
//        -> issue, stall, flush, busy, pending (scoreboard bits).
module hazard_ctrl
    import proc_pkg::*;
#(
    parameter int OPCODE_WIDTH   = 6,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int INSTR_WIDTH    = 32,
    parameter int MUL_CYCLES     = 2,
    parameter int DIV_CYCLES     = 16
) (
    input  logic                         clk_in,
    input  logic                         RST,
    input  logic                         id_valid,
    input  logic [INSTR_WIDTH-1:0]       id_instr,
    input  logic                         wb_en,
    input  logic [REG_ADDR_WIDTH-1:0]    wb_addr,
    input  logic                         flag_wb,
    input  logic                         ex_redirect,
    output logic                         issue,
    output logic                         stall,
    output logic                         flush,
    output logic                         busy,
    output logic [2**REG_ADDR_WIDTH-1:0] pending
);

    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
    // The issue edge and the final RUN-return cycle are not counted, so the
    // counter starts at CYCLES-2.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

    hz_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      flag_pend_q;

    logic [OPCODE_WIDTH-1:0]   op;
    logic [REG_ADDR_WIDTH-1:0] r1, r2, src_a, dest;
    logic                      rd_a, rd_b, pend_a, pend_b;
    logic                      raw, flag_haz;
    logic                      issue_c, stall_c, flush_c, busy_c;
    logic                      unused_imm;

    assign op         = id_instr[OPCODE_WIDTH-1:0];
    assign r1         = id_instr[OPCODE_WIDTH +: REG_ADDR_WIDTH];
    assign r2         = id_instr[OPCODE_WIDTH+REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    assign unused_imm = ^id_instr[INSTR_WIDTH-1:OPCODE_WIDTH+2*REG_ADDR_WIDTH];

    assign src_a = src1_addr(op, r1);
    assign dest  = dest_addr(op, r1);
    assign rd_a  = reads_r1(op);
    assign rd_b  = reads_r2(op);

    // The register file is write-before-read, so a source being written back
    // this cycle is already safe to read.
    assign raw = (rd_a & pend_a & ~(wb_en && (wb_addr == src_a)))
               | (rd_b & pend_b & ~(wb_en && (wb_addr == r2)));
    assign flag_haz = (op == OP_BRFL) & flag_pend_q & ~flag_wb;

    scoreboard #(.AW(REG_ADDR_WIDTH)) u_scoreboard (
        .clk_in      (clk_in),
        .RST         (RST),
        .set_en_i    (issue_c & writes_dest(op)),
        .set_addr_i  (dest),
        .clr_en_i    (wb_en),
        .clr_addr_i  (wb_addr),
        .rd_a_addr_i (src_a),
        .rd_a_pend_o (pend_a),
        .rd_b_addr_i (r2),
        .rd_b_pend_o (pend_b),
        .pending_o   (pending)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        issue_c = 1'b0;
        stall_c = 1'b0;
        flush_c = 1'b0;
        busy_c  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // A redirect kills the ID instruction. It neither issues nor stalls.
                flush_c = ex_redirect;
                issue_c = id_valid & ~raw & ~flag_haz & ~ex_redirect;
                stall_c = id_valid & (raw | flag_haz) & ~ex_redirect;
                if (issue_c && (op == OP_MUL) && (MUL_CYCLES > 1)) begin
                    cnt_d   = MUL_LOAD;
                    state_d = ST_BUSY;
                end else if (issue_c && (op == OP_DIV) && (DIV_CYCLES > 1)) begin
                    cnt_d   = DIV_LOAD;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                busy_c  = 1'b1;
                if (cnt_q == '0) state_d = ST_RUN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        if (RST) begin
            issue_c = 1'b0;
            stall_c = 1'b0;
            flush_c = 1'b0;
            busy_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            flag_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (issue_c && (op == OP_CMP)) flag_pend_q <= 1'b1;
            else if (flag_wb)              flag_pend_q <= 1'b0;
        end
    end

    assign issue = issue_c;
    assign stall = stall_c;
    assign flush = flush_c;
    assign busy  = busy_c;

    // EX cannot resolve a branch while the multi-cycle unit owns it. A redirect
    // here is ignored by the FSM.
    a_no_redirect_in_busy: assert property (@(posedge clk_in) disable iff (RST)
        !((state_q == ST_BUSY) && ex_redirect));

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Issue controller for the decode stage (pipeline2). A per-register scoreboard tracks writes that have issued but not yet written back. The controller stalls the instruction in ID on read-after-write or flag hazards and while a multi-cycle MUL/DIV occupies EX. It also flushes IF/ID when EX resolves a taken control transfer.

## Interface
Parameters:
- `OPCODE_WIDTH`, default 6: opcode field, `instr[OPCODE_WIDTH-1:0]`.
- `REG_ADDR_WIDTH`, default 5: register address width; 32 registers.
- `INSTR_WIDTH`, default 32: opcode + R1 + R2 + 16-bit immediate.
- `MUL_CYCLES`, default 2: EX occupancy of MUL, ≥1.
- `DIV_CYCLES`, default 16: EX occupancy of DIV, ≥1.

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  synchronous reset, active-high.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_instr`  in  INSTR_WIDTH  ID instruction. R1 = `[OPCODE_WIDTH+REG_ADDR_WIDTH-1:OPCODE_WIDTH]`, R2 = next REG_ADDR_WIDTH bits.
- `wb_en`  in  1  register-file write this cycle; same meaning as pipeline2 `reg_en`.
- `wb_addr`  in  REG_ADDR_WIDTH  write address; same meaning as `reg_addr`.
- `flag_wb`  in  1  CMP result written to the flags this cycle.
- `ex_redirect`  in  1  EX resolved a taken JR/JPC/BRFL/CALL/RET.
- `issue`  out  1  ID instruction advances to EX at this edge.
- `stall`  out  1  hold PC and IF/ID.
- `flush`  out  1  invalidate IF/ID.
- `busy`  out  1  multi-cycle unit occupied.
- `pending`  out  2**REG_ADDR_WIDTH  scoreboard bits.

## Operation
Opcode classes (reads / write):
- ADD, SUB, MUL, DIV, AND, OR: read R1, R2; write R1.
- NOT, LW: read R2; write R1.
- LW_IMM: no reads; write R1.
- SW: read R1, R2; no write.
- CMP: read R1, R2; writes flags.
- JR: read R1.
- BRFL: reads flags.
- CALL: writes R31.
- RET: reads R31.
- JPC, NOP: no reads, no writes.
- Undefined opcodes are treated as NOP.

Hazard rules:
- `raw` = a source register has its `pending` bit set and is not being written back this cycle (`wb_en && wb_addr == src` clears the hazard; the register file is write-before-read).
- `flag_haz` = BRFL in ID, `flag_pend` set, and `flag_wb` low.

FSM, states RUN and BUSY:
- RUN: `issue = id_valid & ~raw & ~flag_haz & ~ex_redirect`.
  - `stall = id_valid & (raw | flag_haz) & ~ex_redirect`.
  - Issuing MUL with MUL_CYCLES>1, or DIV with DIV_CYCLES>1: load `cnt = CYCLES-2` and go to BUSY.
- BUSY: `issue=0`, `stall=1`, `busy=1`.
  - Each cycle: when `cnt==0` go to RUN, else `cnt--`.
  - `ex_redirect` in BUSY is illegal: ignore it and flag it with an assertion.
- `flush = ex_redirect` in RUN. Redirect wins over stall. A flushed instruction never issues and never touches the scoreboard.

Scoreboard:
- On issue of a writer: set `pending[dest]`.
- On `wb_en`: clear `pending[wb_addr]`.
- Same edge, same address: set wins.
- `flag_pend`: set on CMP issue, cleared on `flag_wb`; set wins.

## Timing
- Reset: `pending`=0, `flag_pend`=0, state RUN, `cnt`=0. While `RST` is high, `issue`, `stall`, `flush`, `busy` are all 0. Reset mid-BUSY returns to RUN on the next edge.
- `issue`, `stall`, `flush` are combinational from inputs and current state; there is no added latency.
- Scoreboard updates are visible the cycle after the edge.
- A MUL/DIV issued at edge t produces `busy=1` for exactly CYCLES-1 cycles after t.
- The next instruction can issue at edge t+CYCLES, provided it has no hazard.
- A dependent instruction stalls until the cycle in which its producer writes back, and issues at that edge.

## Structure
- Shared package `proc_pkg`: OPCODE constants (LW, LW_IMM, SW, ADD, …, NOP), width parameters, and functions `reads_r1`, `reads_r2`, `writes_dest`, `dest_addr`. The package is shared with pipeline2 and its testbench.
- One sub-module, `scoreboard`: pending-bit array with set/clear ports and two combinational lookup ports.
- The FSM and counter live in `hazard_ctrl`.

## Test plan
- Reset, then `id_valid=1` with ADD R3,R17 → `issue=1`; next cycle `pending[3]=1`. Then `wb_en=1`, `wb_addr=3` → `pending[3]=0` after the edge.
- ADD R2 issued, then SUB R4,R2 in ID → `stall=1`, `issue=0` until the cycle with `wb_en`/`wb_addr=2`; SUB issues at that edge.
- DIV R2,R0 issued with DIV_CYCLES=16 → `busy=1`, `stall=1` for 15 cycles; the following NOP issues at edge t+16.
- CMP R0,R3 then BRFL → BRFL stalls until `flag_wb=1`, then issues.
- `ex_redirect=1` while a stalled SUB is in ID → `flush=1`, `stall=0`, `issue=0`; scoreboard unchanged.
- Same-edge issue of LW R5 and `wb_en`/`wb_addr=5` → `pending[5]=1`. `RST=1` during BUSY → next cycle `busy=0`, `pending=0`.
